// File: rtl/cmerger_pkg.sv
// cmerger_pkg: shared constants and FSM state type for the four-source merger.
package cmerger_pkg;
    localparam int N_SRC     = 4;
    localparam int DELAY_DEF = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_WAIT_FREE, ST_RELEASE} state_t;
endpackage

// File: rtl/cmerger4_cache_if.sv
// cmerger4_cache_if: upstream/downstream handshake bundle; o_overflow exists only with CMERGER4_OVF_DETECT_EN.
interface cmerger4_cache_if #(parameter int DATA_W = 32);
    logic              i_drive0, i_drive1, i_drive2, i_drive3;
    logic [DATA_W-1:0] i_data0, i_data1, i_data2, i_data3;
    logic              o_free0, o_free1, o_free2, o_free3;
    logic              o_fire;
    logic [1:0]        o_grant;
    logic              o_driveNext;
    logic [DATA_W-1:0] o_data;
    logic              i_freeNext;
    logic              o_busy;
`ifdef CMERGER4_OVF_DETECT_EN
    logic              o_overflow;
`endif
    modport slave (
        input  i_drive0, i_drive1, i_drive2, i_drive3,
        input  i_data0, i_data1, i_data2, i_data3, i_freeNext,
        output o_free0, o_free1, o_free2, o_free3,
        output o_fire, o_grant, o_driveNext, o_data, o_busy
`ifdef CMERGER4_OVF_DETECT_EN
        , output o_overflow
`endif
    );
    modport master (
        output i_drive0, i_drive1, i_drive2, i_drive3,
        output i_data0, i_data1, i_data2, i_data3, i_freeNext,
        input  o_free0, o_free1, o_free2, o_free3,
        input  o_fire, o_grant, o_driveNext, o_data, o_busy
`ifdef CMERGER4_OVF_DETECT_EN
        , input o_overflow
`endif
    );
endinterface

// File: rtl/cmerger_rr_arb.sv
// cmerger_rr_arb: combinational round-robin picker, searching upward from last_grant+1.
module cmerger_rr_arb
    import cmerger_pkg::*;
(
    input  logic [N_SRC-1:0] pending,
    input  logic [1:0]       last_grant,
    output logic [1:0]       grant,
    output logic             any_valid
);
    always_comb begin
        grant     = last_grant;
        any_valid = |pending;
        // Walk from farthest to nearest so the nearest pending source wins.
        for (int k = N_SRC; k >= 1; k--) begin
            if (pending[2'(last_grant + 2'(k))]) grant = 2'(last_grant + 2'(k));
        end
    end
endmodule

// File: rtl/cmerger4_cache.sv
// cmerger4_cache: merges four pulse-handshake sources onto one downstream stage with round-robin grant.
// Define CMERGER4_OVF_DETECT_EN to add the sticky o_overflow drop indicator.
module cmerger4_cache
    import cmerger_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DELAY  = DELAY_DEF
) (
    input logic              clk,
    input logic              rst,
    cmerger4_cache_if.slave  bus
);
    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [N_SRC-1:0]  drive, pend, granted, drop;
    logic [DATA_W-1:0] din [N_SRC];
    logic [DATA_W-1:0] payload [N_SRC];
    logic [DATA_W-1:0] data_r;
    logic [1:0]        last_grant, grant_r, pick;
    logic              any_valid, fire;

    assign drive  = {bus.i_drive3, bus.i_drive2, bus.i_drive1, bus.i_drive0};
    assign din[0] = bus.i_data0;
    assign din[1] = bus.i_data1;
    assign din[2] = bus.i_data2;
    assign din[3] = bus.i_data3;

    cmerger_rr_arb u_arb (
        .pending    (pend),
        .last_grant (last_grant),
        .grant      (pick),
        .any_valid  (any_valid)
    );

    assign fire    = (state == ST_IDLE) && any_valid;
    assign granted = fire ? 4'b0001 << pick : 4'b0000;
    // A source being granted this cycle may re-arm; any other busy source drops its drive.
    assign drop    = drive & pend & ~granted;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                state_nx = any_valid ? ST_DELAY : ST_IDLE;
                cnt_nx   = any_valid ? 4'(DELAY - 1) : cnt;
            end
            ST_DELAY: begin
                state_nx = (cnt == 4'd0) ? ST_WAIT_FREE : ST_DELAY;
                cnt_nx   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            end
            ST_WAIT_FREE: state_nx = bus.i_freeNext ? ST_RELEASE : ST_WAIT_FREE;
            default:      state_nx = ST_IDLE;
        endcase
        bus.o_fire      = fire;
        bus.o_grant     = fire ? pick : grant_r;
        bus.o_data      = fire ? payload[pick] : data_r;
        bus.o_driveNext = (state == ST_DELAY) && (cnt == 4'd0);
        bus.o_busy      = state != ST_IDLE;
        bus.o_free0     = (state == ST_RELEASE) && (grant_r == 2'd0);
        bus.o_free1     = (state == ST_RELEASE) && (grant_r == 2'd1);
        bus.o_free2     = (state == ST_RELEASE) && (grant_r == 2'd2);
        bus.o_free3     = (state == ST_RELEASE) && (grant_r == 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            pend       <= '0;
            payload    <= '{default: '0};
            data_r     <= '0;
            grant_r    <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= (pend & ~granted) | drive;
            for (int i = 0; i < N_SRC; i++) begin
                if (drive[i] && !drop[i]) payload[i] <= din[i];
            end
            if (fire) begin
                last_grant <= pick;
                grant_r    <= pick;
                data_r     <= payload[pick];
            end
        end
    end

`ifdef CMERGER4_OVF_DETECT_EN
    logic ovf;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf <= 1'b0;
        else      ovf <= ovf | (|drop);
    end
    assign bus.o_overflow = ovf;
`endif
endmodule

// File: tb/tb_cmerger4_cache.sv
// tb_cmerger4_cache: directed scenarios plus random traffic against a transaction-timing reference model.
module tb_cmerger4_cache;
    import cmerger_pkg::*;
    localparam int DW = 32;
    localparam int DL = DELAY_DEF;

    logic clk, rst;
    cmerger4_cache_if #(.DATA_W(DW)) bus ();
    cmerger4_cache #(.DATA_W(DW), .DELAY(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    drv;
    logic [DW-1:0] dat [4];
    logic          fn;

    // Model: pending/payload per source plus the cycle number of the current grant.
    bit            m_pend [4];
    logic [DW-1:0] m_pay [4];
    int            m_last, m_gidx, m_tf, cyc;
    logic [DW-1:0] m_gdata;
    bit            m_active, m_rel, m_ovf;

    logic          s_fire, s_dn, s_busy;
    logic [1:0]    s_grant;
    logic [DW-1:0] s_data;
    logic [3:0]    s_free;
    int            errors, checks, nfree;
    int            gq[$];
    logic [DW-1:0] dq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= 4; k++) if (m_pend[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    task automatic apply();
        bus.i_drive0 = drv[0]; bus.i_drive1 = drv[1]; bus.i_drive2 = drv[2]; bus.i_drive3 = drv[3];
        bus.i_data0 = dat[0]; bus.i_data1 = dat[1]; bus.i_data2 = dat[2]; bus.i_data3 = dat[3];
        bus.i_freeNext = fn;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_pay[i] = '0; end
        m_last = 3; m_gidx = 0; m_gdata = '0; m_active = 0; m_rel = 0; m_ovf = 0;
    endtask

    task automatic cycle();
        int p;
        logic [3:0] efree;
        logic efire, edn;
        logic [1:0] eg;
        logic [DW-1:0] ed;
        apply();
        @(negedge clk);
        p = model_pick();
        efire = 0; edn = 0; efree = 0; eg = 2'(m_gidx); ed = m_gdata;
        if (m_rel) efree = 4'b0001 << m_gidx;
        else if (!m_active && p >= 0) begin efire = 1; eg = 2'(p); ed = m_pay[p]; end
        else if (m_active) edn = (cyc == m_tf + DL);
        s_fire = bus.o_fire; s_dn = bus.o_driveNext; s_busy = bus.o_busy;
        s_grant = bus.o_grant; s_data = bus.o_data;
        s_free = {bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0};
        chk("fire", 64'(s_fire), 64'(efire));
        chk("grant", 64'(s_grant), 64'(eg));
        chk("data", 64'(s_data), 64'(ed));
        chk("drive_next", 64'(s_dn), 64'(edn));
        chk("busy", 64'(s_busy), 64'(m_active));
        chk("free", 64'(s_free), 64'(efree));
`ifdef CMERGER4_OVF_DETECT_EN
        chk("overflow", 64'(bus.o_overflow), 64'(m_ovf));
`endif
        if (s_fire === 1'b1) begin gq.push_back(int'(s_grant)); dq.push_back(s_data); end
        if (s_free !== 4'b0000) nfree++;
        @(posedge clk); #1;
        if (m_rel) begin m_rel = 0; m_active = 0; end
        else if (!m_active && p >= 0) begin
            m_active = 1; m_tf = cyc; m_gidx = p; m_gdata = m_pay[p]; m_last = p; m_pend[p] = 0;
        end else if (m_active && cyc > m_tf + DL && fn) m_rel = 1;
        for (int i = 0; i < 4; i++) begin
            if (drv[i]) begin
                if (m_pend[i]) m_ovf = 1;
                else begin m_pend[i] = 1; m_pay[i] = dat[i]; end
            end
        end
        cyc++;
        drv = '0; fn = 0;
    endtask

    task automatic do_reset();
        rst = 0; drv = '0; fn = 0; apply();
        #1;
        chk("rst_fire", 64'(bus.o_fire), 64'd0);
        chk("rst_drive_next", 64'(bus.o_driveNext), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_grant", 64'(bus.o_grant), 64'd0);
        chk("rst_data", 64'(bus.o_data), 64'd0);
        chk("rst_free", 64'({bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0}), 64'd0);
`ifdef CMERGER4_OVF_DETECT_EN
        chk("rst_overflow", 64'(bus.o_overflow), 64'd0);
`endif
        @(posedge clk); #1;
        chk("rst_hold_free", 64'({bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0}), 64'd0);
        rst = 1;
        model_reset();
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; nfree = 0;
        rst = 1; drv = '0; fn = 0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        apply();
        model_reset();
        #2;
        do_reset();

        // Single request on source 2
        drv = 4'b0100; dat[2] = 32'hA5; cycle();
        cycle(); chk("single_fire", 64'(s_fire), 64'd1); chk("single_grant", 64'(s_grant), 64'd2);
        cycle();
        cycle(); chk("single_drive_next", 64'(s_dn), 64'd1); chk("single_data", 64'(s_data), 64'hA5);
        cycle(); cycle();
        fn = 1; cycle();
        cycle(); chk("single_free", 64'(s_free), 64'b0100);
        cycle();

        // All four at once
        do_reset();
        gq.delete(); nfree = 0;
        drv = 4'hF; for (int i = 0; i < 4; i++) dat[i] = 32'h10 + i;
        cycle();
        repeat (24) begin fn = 1; cycle(); end
        chk("all4_count", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("all4_order", 64'(gq[i]), 64'(i));
        chk("all4_frees", 64'(nfree), 64'd4);

        // Fairness between source 1 re-requesting and source 3
        do_reset();
        gq.delete();
        drv = 4'b1010; dat[1] = 32'h111; dat[3] = 32'h333; cycle();
        repeat (30) begin
            drv[1] = s_free[1]; drv[3] = s_free[3]; fn = 1; cycle();
        end
        chk("rr_count_min", 64'(gq.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_alternate", 64'(gq[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

        // Re-drive of a pending source is dropped
        do_reset();
        gq.delete(); dq.delete();
        drv = 4'b0100; dat[2] = 32'h2; cycle();
        drv = 4'b0001; dat[0] = 32'h11; cycle();
        drv = 4'b0001; dat[0] = 32'h22; cycle();
`ifdef CMERGER4_OVF_DETECT_EN
        chk("drop_overflow", 64'(bus.o_overflow), 64'd1);
`endif
        repeat (14) begin fn = 1; cycle(); end
        chk("drop_count", 64'(gq.size()), 64'd2);
        if (dq.size() >= 2) chk("drop_payload", 64'(dq[1]), 64'h11);

        // freeNext during DELAY is ignored
        do_reset();
        drv = 4'b1000; dat[3] = 32'h3C; cycle();
        cycle();
        fn = 1; cycle();
        repeat (4) cycle();
        chk("early_free_busy", 64'(s_busy), 64'd1);
        chk("early_free_none", 64'(s_free), 64'd0);
        fn = 1; cycle();
        cycle(); chk("late_free", 64'(s_free), 64'b1000);

        // Reset while waiting for downstream completion
        do_reset();
        drv = 4'b0010; dat[1] = 32'h55; cycle();
        repeat (5) cycle();
        chk("pre_rst_busy", 64'(s_busy), 64'd1);
        do_reset();
        drv = 4'b0010; dat[1] = 32'h77; cycle();
        cycle(); chk("post_rst_fire", 64'(s_fire), 64'd1); chk("post_rst_data", 64'(s_data), 64'h77);
        repeat (8) begin fn = 1; cycle(); end

        // Random traffic
        do_reset();
        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                drv[i] = ($urandom_range(0, 3) == 0);
                dat[i] = $urandom;
            end
            fn = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
